// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit.
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// drives the datapath controls plus IRWrite/PCWrite/IorD. Memory accesses use a
// ready handshake with an optional timeout. The unit halts on SYSTEM, on an
// illegal opcode or on a memory timeout, and counts retired instructions.
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             IorD,
    output logic             Branch,
    output logic             Jump,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrc_1,
    output logic             ALUSrc_2,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic [1:0]       RegWriteSel,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_ARITHI = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ARITHR = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // The wait counter only has to reach MEM_WAIT_MAX-1; with the timeout
    // disabled it is free to wrap since nothing looks at it.
    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [1:0]         r_cause;
    logic [CNT_W-1:0]   r_instret;

    logic w_is_load, w_is_store, w_is_branch, w_is_fence, w_is_system;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_arith;
    logic w_legal;
    logic w_timeout;
    logic [1:0] w_aluop;
    logic       w_src1;
    logic       w_src2;

    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_is_fence  = (opcode == OP_FENCE);
    assign w_is_system = (opcode == OP_SYSTEM);
    assign w_is_jal    = (opcode == OP_JAL);
    assign w_is_jalr   = (opcode == OP_JALR);
    assign w_is_lui    = (opcode == OP_LUI);
    assign w_is_auipc  = (opcode == OP_AUIPC);
    assign w_is_arith  = (opcode == OP_ARITHI) || (opcode == OP_ARITHR);
    assign w_legal     = w_is_load || w_is_store || w_is_branch || w_is_fence ||
                         w_is_system || w_is_jal || w_is_jalr || w_is_lui ||
                         w_is_auipc || w_is_arith;

    // A not-ready cycle with the counter already at its last value is the
    // timeout cycle; a ready on that same cycle still completes the access.
    assign w_timeout = (MEM_WAIT_MAX > 0) && !mem_ready && (r_wait == WAIT_LAST);

    // Per-opcode ALU operand/operation selection, used from EXECUTE to WRITEBACK.
    always_comb begin
        w_aluop = 2'b00;
        w_src1  = 1'b0;
        w_src2  = 1'b0;
        case (opcode)
            OP_BRANCH: begin w_aluop = 2'b01; w_src1 = 1'b0; w_src2 = 1'b0; end
            OP_LOAD,
            OP_STORE,
            OP_JALR:   begin w_aluop = 2'b00; w_src1 = 1'b0; w_src2 = 1'b1; end
            OP_JAL:    begin w_aluop = 2'b00; w_src1 = 1'b1; w_src2 = 1'b1; end
            OP_ARITHI: begin w_aluop = 2'b10; w_src1 = 1'b0; w_src2 = 1'b1; end
            OP_ARITHR: begin w_aluop = 2'b10; w_src1 = 1'b0; w_src2 = 1'b0; end
            OP_AUIPC,
            OP_LUI:    begin w_aluop = 2'b11; w_src1 = 1'b1; w_src2 = 1'b1; end
            OP_FENCE:  begin w_aluop = 2'b00; w_src1 = 1'b1; w_src2 = 1'b0; end
            default:   begin w_aluop = 2'b00; w_src1 = 1'b0; w_src2 = 1'b0; end
        endcase
    end

    // Datapath controls decoded from the current state, opcode and memory handshake.
    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        Branch      = 1'b0;
        Jump        = 1'b0;
        MemRead     = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc_1    = 1'b0;
        ALUSrc_2    = 1'b0;
        RegWrite    = 1'b0;
        ALUOp       = 2'b00;
        RegWriteSel = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
            end
            S_EXECUTE: begin
                ALUOp    = w_aluop;
                ALUSrc_1 = w_src1;
                ALUSrc_2 = w_src2;
                if (w_is_branch) begin
                    Branch  = 1'b1;
                    PCWrite = 1'b1;
                end
                if (w_is_fence) begin
                    PCWrite = 1'b1;
                end
            end
            S_MEM: begin
                ALUOp    = w_aluop;
                ALUSrc_1 = w_src1;
                ALUSrc_2 = w_src2;
                IorD     = 1'b1;
                MemRead  = w_is_load;
                MemWrite = w_is_store;
                PCWrite  = w_is_store && mem_ready;
            end
            S_WB: begin
                ALUOp    = w_aluop;
                ALUSrc_1 = w_src1;
                ALUSrc_2 = w_src2;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (w_is_load) begin
                    MemtoReg    = 1'b1;
                    RegWriteSel = 2'b00;
                end else if (w_is_jal || w_is_jalr) begin
                    Jump        = 1'b1;
                    Branch      = 1'b1;
                    RegWriteSel = 2'b10;
                end else if (w_is_lui) begin
                    RegWriteSel = 2'b11;
                end else begin
                    RegWriteSel = 2'b01;
                end
            end
            default: ;
        endcase
    end

    // State sequencing, memory wait counting, halt cause capture and retire counting.
    // PCWrite marks the single retire cycle of every instruction, so it drives instret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_cause   <= 2'b00;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_cause <= 2'b11;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_is_system) begin
                        r_state <= S_HALT;
                        r_cause <= 2'b01;
                    end else if (!w_legal) begin
                        r_state <= S_HALT;
                        r_cause <= 2'b10;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_wait <= '0;
                    if (w_is_branch || w_is_fence) begin
                        r_state <= S_FETCH;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_wait  <= '0;
                        r_state <= w_is_store ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_cause <= 2'b11;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (PCWrite) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign halted     = (r_state == S_HALT);
    assign halt_cause = r_cause;
    assign instret    = r_instret;

endmodule
